motion_accum: RTL and testbench

- Consumes the 4-lane absolute-difference vector produced by the frame-differencing stage.
- Per beat: counts lanes whose difference exceeds a pixel threshold.
- Per frame: accumulates that count into a frame total and raises a motion flag once the total reaches a count threshold.
- Sits directly downstream of the differencing stage; the result feeds display/LED logic through a valid/ready handshake.

---
 rtl/motion_pkg.sv | 15 +
 rtl/motion_accum_lane_hit_count.sv | 22 ++
 rtl/motion_accum.sv | 127 ++++++++++++
 tb/tb_motion_accum.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// Shared constants and FSM state encoding for the frame motion accumulator.
// Lane count and popcount width must stay consistent with the differencing stage.
package motion_pkg;

  localparam int NUM_LANES = 4;
  localparam int POP_W     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FLUSH  = 2'd2,
    REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/motion_accum_lane_hit_count.sv
// Combinational per-beat hit counter: counts lanes whose difference is
// strictly greater than the pixel threshold (unsigned compare).
module lane_hit_count
  import motion_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [NUM_LANES*WIDTH-1:0] vec_diff,
  input  logic [WIDTH-1:0]           pix_thresh,
  output logic [POP_W-1:0]           pop_count
);

  always_comb begin
    pop_count = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (vec_diff[i*WIDTH +: WIDTH] > pix_thresh) begin
        pop_count = pop_count + POP_W'(1);
      end
    end
  end

endmodule

// File: rtl/motion_accum.sv
// Frame motion accumulator: stage 1 registers the per-beat hit count, stage 2
// accumulates it with saturation and the FSM reports one result per frame.
module motion_accum
  import motion_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [NUM_LANES*WIDTH-1:0] vec_diff,
  input  logic [WIDTH-1:0]           pix_thresh,
  input  logic [CNT_W-1:0]           count_thresh,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           motion_count,
  output logic                       motion_flag,
  output logic                       count_sat
);

  localparam int SUM_W = CNT_W + 1;

  state_t             r_state;
  logic               r_s1_valid;
  logic               r_s1_last;
  logic [POP_W-1:0]   r_s1_pop;
  logic [CNT_W-1:0]   r_acc;
  logic               r_count_sat;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_motion_count;
  logic               r_motion_flag;

  logic [POP_W-1:0]   w_pop;
  logic               w_accept;
  logic [SUM_W-1:0]   w_sum;
  logic               w_ovf;
  logic [CNT_W-1:0]   w_acc_next;

  lane_hit_count #(
    .WIDTH(WIDTH)
  ) u_lane_hit_count (
    .vec_diff  (vec_diff),
    .pix_thresh(pix_thresh),
    .pop_count (w_pop)
  );

  // in_ready is gated by reset directly so upstream never sees a grant while reset is held.
  assign in_ready = !reset && ((r_state == IDLE) || (r_state == ACCUM));
  assign w_accept = in_valid && in_ready;

  // The carry out of the widened sum marks an add that would pass the counter maximum.
  assign w_sum      = SUM_W'(r_acc) + SUM_W'(r_s1_pop);
  assign w_ovf      = w_sum[CNT_W];
  assign w_acc_next = w_ovf ? '1 : w_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_pop   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_last  <= w_accept && in_last;
      r_s1_pop   <= w_accept ? w_pop : '0;
    end
  end

  // The report is built from the accumulator's next value so out_valid rises two cycles after the last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_acc          <= '0;
      r_count_sat    <= 1'b0;
      r_out_valid    <= 1'b0;
      r_motion_count <= '0;
      r_motion_flag  <= 1'b0;
    end else begin
      if (r_s1_valid) begin
        r_acc <= w_acc_next;
        if (w_ovf) begin
          r_count_sat <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= in_last ? FLUSH : ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept && in_last) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (r_s1_valid && r_s1_last) begin
            r_motion_count <= w_acc_next;
            r_motion_flag  <= (w_acc_next >= count_thresh);
            r_out_valid    <= 1'b1;
            r_state        <= REPORT;
          end
        end
        REPORT: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_count_sat <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid    = r_out_valid;
  assign motion_count = r_motion_count;
  assign motion_flag  = r_motion_flag;
  assign count_sat    = r_count_sat;

endmodule

// File: tb/tb_motion_accum.sv
// Self-checking bench for motion_accum: directed frames plus randomized frames
// checked against a frame-level arithmetic model of hit counting and saturation.
module tb_motion_accum;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [15:0]      vec_diff;
  logic [WIDTH-1:0] pix_thresh;
  logic [CNT_W-1:0] count_thresh;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] motion_count;
  logic             motion_flag;
  logic             count_sat;

  int checkCount = 0;
  int errorCount = 0;
  logic [15:0] frameBeats[$];

  motion_accum #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .vec_diff    (vec_diff),
    .pix_thresh  (pix_thresh),
    .count_thresh(count_thresh),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .motion_count(motion_count),
    .motion_flag (motion_flag),
    .count_sat   (count_sat)
  );

  always #5 clk = ~clk;

  // Number of lanes strictly above the pixel threshold in one beat.
  function automatic int hitsOf(input logic [15:0] v, input logic [3:0] pix);
    int h;
    logic [3:0] lane;
    h = 0;
    for (int i = 0; i < 4; i++) begin
      lane = v[i*4 +: 4];
      if (lane > pix) h++;
    end
    return h;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      in_last  = 1'($urandom);
      vec_diff = 16'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Presents one beat and holds it until accepted; entered and left just after a rising edge.
  task automatic applyStimulus(input logic [15:0] v, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    vec_diff = v;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("acceptBeat", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // gapMode: 0 back-to-back, 1 one idle cycle between beats, 2 random idle cycles.
  task automatic runFrame(input string name, input int gapMode, input int holdCycles);
    int total;
    int expCount;
    logic expFlag;
    logic expSat;
    int n;
    n = frameBeats.size();
    total = 0;
    for (int i = 0; i < n; i++) total += hitsOf(frameBeats[i], pix_thresh);
    expCount = (total > MAXC) ? MAXC : total;
    expSat   = (total > MAXC);
    expFlag  = (expCount >= int'(count_thresh));

    for (int i = 0; i < n; i++) begin
      if (gapMode == 1 && i > 0) idleCycles(1);
      if (gapMode == 2) idleCycles($urandom_range(0, 2));
      applyStimulus(frameBeats[i], (i == n - 1));
    end

    @(negedge clk);
    checkOutput({name, ":validAtN1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({name, ":validAtN2"}, {31'd0, out_valid}, 32'd1);
    checkOutput({name, ":count"}, {28'd0, motion_count}, 32'(expCount));
    checkOutput({name, ":flag"}, {31'd0, motion_flag}, {31'd0, expFlag});
    checkOutput({name, ":sat"}, {31'd0, count_sat}, {31'd0, expSat});

    for (int h = 0; h < holdCycles; h++) begin
      in_valid = 1'b1;
      in_last  = 1'($urandom);
      vec_diff = 16'($urandom);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput({name, ":holdReady"}, {31'd0, in_ready}, 32'd0);
      checkOutput({name, ":holdValid"}, {31'd0, out_valid}, 32'd1);
      checkOutput({name, ":holdCount"}, {28'd0, motion_count}, 32'(expCount));
      checkOutput({name, ":holdFlag"}, {31'd0, motion_flag}, {31'd0, expFlag});
    end

    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput({name, ":validCleared"}, {31'd0, out_valid}, 32'd0);
    checkOutput({name, ":readyAfter"}, {31'd0, in_ready}, 32'd1);
    checkOutput({name, ":satCleared"}, {31'd0, count_sat}, 32'd0);
    checkOutput({name, ":countHeld"}, {28'd0, motion_count}, 32'(expCount));
    @(posedge clk); #1;
    frameBeats.delete();
  endtask

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b1;
    in_last      = 1'b0;
    vec_diff     = 16'hFFFF;
    pix_thresh   = 4'd0;
    count_thresh = 4'd0;
    out_ready    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("resetReady", {31'd0, in_ready}, 32'd0);
    checkOutput("resetValid", {31'd0, out_valid}, 32'd0);
    checkOutput("resetCount", {28'd0, motion_count}, 32'd0);
    checkOutput("resetFlag", {31'd0, motion_flag}, 32'd0);
    checkOutput("resetSat", {31'd0, count_sat}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postResetReady", {31'd0, in_ready}, 32'd1);
    checkOutput("postResetValid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    pix_thresh = 4'd3; count_thresh = 4'd2;
    frameBeats.push_back(16'h0934);
    runFrame("singleBeat", 0, 0);

    pix_thresh = 4'd4; count_thresh = 4'd7;
    repeat (3) frameBeats.push_back(16'h0055);
    runFrame("edgeBelow", 0, 0);
    count_thresh = 4'd6;
    repeat (3) frameBeats.push_back(16'h0055);
    runFrame("edgeAt", 0, 5);

    pix_thresh = 4'd0; count_thresh = 4'd15;
    repeat (5) frameBeats.push_back(16'hFFFF);
    runFrame("saturate", 0, 0);
    pix_thresh = 4'd15; count_thresh = 4'd0;
    repeat (3) frameBeats.push_back(16'hFFFF);
    runFrame("noHits", 0, 0);

    pix_thresh = 4'd0; count_thresh = 4'd3;
    applyStimulus(16'hFFFF, 1'b0);
    applyStimulus(16'hFFFF, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midResetReady", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("abortNoValid", {31'd0, out_valid}, 32'd0);
      checkOutput("abortCount", {28'd0, motion_count}, 32'd0);
      @(posedge clk); #1;
    end
    frameBeats.push_back(16'h1111);
    runFrame("afterAbort", 0, 0);

    pix_thresh = 4'd7; count_thresh = 4'd2;
    frameBeats.push_back(16'h0008);
    frameBeats.push_back(16'h0008);
    runFrame("stalled", 1, 0);

    for (int f = 0; f < 24; f++) begin
      case ($urandom_range(0, 3))
        0:       pix_thresh = 4'd0;
        1:       pix_thresh = 4'd15;
        default: pix_thresh = 4'($urandom);
      endcase
      count_thresh = 4'($urandom);
      repeat ($urandom_range(1, 6)) frameBeats.push_back(16'($urandom));
      runFrame("random", 2, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
